// File: rtl/dmem_port_arbiter.sv
// Round-robin arbiter sharing one synchronous data-memory port between the CPU
// and the loader port; registers the memory command and steers read data back.
module dmem_port_arbiter #(
  parameter int AW     = 12,
  parameter int DW     = 32,
  parameter int RD_LAT = 1
) (
  input  logic          clock_i,
  input  logic          reset_ni,
  input  logic          cpu_req_i,
  input  logic          cpu_wren_i,
  input  logic [AW-1:0] cpu_addr_i,
  input  logic [DW-1:0] cpu_wdata_i,
  output logic          cpu_gnt_o,
  output logic          cpu_rvalid_o,
  output logic [DW-1:0] cpu_rdata_o,
  input  logic          ldr_req_i,
  input  logic          ldr_wren_i,
  input  logic [AW-1:0] ldr_addr_i,
  input  logic [DW-1:0] ldr_wdata_i,
  output logic          ldr_gnt_o,
  output logic          ldr_rvalid_o,
  output logic [DW-1:0] ldr_rdata_o,
  output logic [AW-1:0] mem_address_o,
  output logic [DW-1:0] mem_data_o,
  output logic          mem_wren_o,
  input  logic [DW-1:0] mem_q_i
);
  localparam int NP = 2;
  localparam int CW = $clog2(RD_LAT + 1);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  // Port index 0 = CPU, 1 = LDR.
  logic [NP-1:0]         req, wren_in, gnt, rvalid;
  logic [NP-1:0][AW-1:0] addr_in;
  logic [NP-1:0][DW-1:0] wdata_in, rdata;

  assign req      = {ldr_req_i, cpu_req_i};
  assign wren_in  = {ldr_wren_i, cpu_wren_i};
  assign addr_in  = {ldr_addr_i, cpu_addr_i};
  assign wdata_in = {ldr_wdata_i, cpu_wdata_i};

  logic [1:0]    state_q, state_d;
  logic          win_q, win_d, last_q, last_d, wren_q, wren_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pick;

  // Contention goes to the port that did not win last; otherwise the lone requester.
  assign pick = (req[0] && req[1]) ? ~last_q : req[1];

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    last_d  = last_q;
    wren_d  = wren_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          win_d   = pick;
          last_d  = pick;
          wren_d  = wren_in[pick];
          addr_d  = addr_in[pick];
          wdata_d = wdata_in[pick];
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = CW'(RD_LAT);
        state_d = wren_q ? S_IDLE : S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= S_IDLE;
      win_q   <= 1'b0;
      last_q  <= 1'b1;
      wren_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      last_q  <= last_d;
      wren_q  <= wren_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
    end
  end

  // Strobes decode straight from state so reset clears them without waiting for an edge.
  for (genvar p = 0; p < NP; p++) begin : g_port
    assign gnt[p]    = (state_q == S_ISSUE) && (win_q == 1'(p));
    assign rvalid[p] = (state_q == S_WAIT) && (cnt_q == CW'(1)) && (win_q == 1'(p));
    assign rdata[p]  = rvalid[p] ? mem_q_i : '0;
  end

  assign cpu_gnt_o     = gnt[0];
  assign ldr_gnt_o     = gnt[1];
  assign cpu_rvalid_o  = rvalid[0];
  assign ldr_rvalid_o  = rvalid[1];
  assign cpu_rdata_o   = rdata[0];
  assign ldr_rdata_o   = rdata[1];
  assign mem_address_o = addr_q;
  assign mem_data_o    = wdata_q;
  assign mem_wren_o    = (state_q == S_ISSUE) && wren_q;
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: transaction-schedule model checked every cycle,
// directed scenarios with literal expectations, plus an RD_LAT=2 instance.
module tb_dmem_port_arbiter;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int RL = 1;
  localparam int NE = 4096;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  initial forever #5 clk = ~clk;

  logic          cpu_req = 0, cpu_wren = 0, ldr_req = 0, ldr_wren = 0;
  logic [AW-1:0] cpu_addr = '0, ldr_addr = '0;
  logic [DW-1:0] cpu_wdata = '0, ldr_wdata = '0;
  logic          cpu_gnt, cpu_rvalid, ldr_gnt, ldr_rvalid, mem_wren;
  logic [DW-1:0] cpu_rdata, ldr_rdata, mem_data, mem_q;
  logic [AW-1:0] mem_address;

  logic          l2_req = 0, l2_wren = 0, c2_zero = 0;
  logic [AW-1:0] l2_addr = '0, c2_addr = '0;
  logic [DW-1:0] l2_wdata = '0, c2_wdata = '0;
  logic          c2_gnt, c2_rvalid, l2_gnt, l2_rvalid, m2_wren;
  logic [DW-1:0] c2_rdata, l2_rdata, m2_data, m2_q, m2_qa;
  logic [AW-1:0] m2_address;

  dmem_port_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RL)) u_dut (
    .clock_i(clk), .reset_ni(rst_n),
    .cpu_req_i(cpu_req), .cpu_wren_i(cpu_wren), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
    .cpu_gnt_o(cpu_gnt), .cpu_rvalid_o(cpu_rvalid), .cpu_rdata_o(cpu_rdata),
    .ldr_req_i(ldr_req), .ldr_wren_i(ldr_wren), .ldr_addr_i(ldr_addr), .ldr_wdata_i(ldr_wdata),
    .ldr_gnt_o(ldr_gnt), .ldr_rvalid_o(ldr_rvalid), .ldr_rdata_o(ldr_rdata),
    .mem_address_o(mem_address), .mem_data_o(mem_data), .mem_wren_o(mem_wren), .mem_q_i(mem_q));

  dmem_port_arbiter #(.AW(AW), .DW(DW), .RD_LAT(2)) u_dut2 (
    .clock_i(clk), .reset_ni(rst_n),
    .cpu_req_i(c2_zero), .cpu_wren_i(c2_zero), .cpu_addr_i(c2_addr), .cpu_wdata_i(c2_wdata),
    .cpu_gnt_o(c2_gnt), .cpu_rvalid_o(c2_rvalid), .cpu_rdata_o(c2_rdata),
    .ldr_req_i(l2_req), .ldr_wren_i(l2_wren), .ldr_addr_i(l2_addr), .ldr_wdata_i(l2_wdata),
    .ldr_gnt_o(l2_gnt), .ldr_rvalid_o(l2_rvalid), .ldr_rdata_o(l2_rdata),
    .mem_address_o(m2_address), .mem_data_o(m2_data), .mem_wren_o(m2_wren), .mem_q_i(m2_q));

  function automatic logic [DW-1:0] init_word(int i);
    return 32'hA5A50000 | 32'(i);
  endfunction

  // Synchronous memories: RD_LAT=1 for u_dut, RD_LAT=2 for u_dut2.
  logic [DW-1:0] mem1 [0:NE-1];
  logic [DW-1:0] mem2 [0:NE-1];
  initial begin
    for (int i = 0; i < NE; i++) begin mem1[i] = init_word(i); mem2[i] = init_word(i); end
    forever begin
      @(posedge clk);
      mem_q <= mem1[mem_address];
      m2_qa <= mem2[m2_address];
      m2_q  <= m2_qa;
      if (mem_wren) mem1[mem_address] = mem_data;
      if (m2_wren) mem2[m2_address] = m2_data;
    end
  end

  int nvec = 0, nmis = 0;
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Model: per-cycle expectation tables filled when an access is granted.
  int cyc = 0, next_free = 0;
  bit last_ldr = 1'b1;
  bit [1:0]    e_gnt [0:NE-1];
  bit [1:0]    e_rv  [0:NE-1];
  bit          e_wr  [0:NE-1];
  bit          e_act [0:NE-1];
  bit [AW-1:0] e_addr[0:NE-1];
  bit [DW-1:0] e_data[0:NE-1];
  bit [DW-1:0] e_rd  [0:NE-1];
  logic [DW-1:0] mmem [0:NE-1];

  initial begin
    for (int i = 0; i < NE; i++) mmem[i] = init_word(i);
    forever begin
      @(posedge clk);
      cyc++;
      if (rst_n && cyc >= next_free && (cpu_req || ldr_req)) begin
        bit w, wr;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        w  = (cpu_req && ldr_req) ? !last_ldr : ldr_req;
        last_ldr = w;
        wr = w ? ldr_wren : cpu_wren;
        a  = w ? ldr_addr : cpu_addr;
        d  = w ? ldr_wdata : cpu_wdata;
        e_gnt[cyc][w] = 1'b1;
        e_act[cyc] = 1'b1; e_addr[cyc] = a; e_wr[cyc] = wr; e_data[cyc] = d;
        if (wr) begin
          mmem[a] = d;
          next_free = cyc + 2;
        end else begin
          for (int j = 1; j <= RL; j++) begin e_act[cyc+j] = 1'b1; e_addr[cyc+j] = a; end
          e_rv[cyc+RL][w] = 1'b1;
          e_rd[cyc+RL] = mmem[a];
          next_free = cyc + 2 + RL;
        end
      end
    end
  end

  initial forever begin
    @(negedge rst_n);
    for (int i = cyc; i < cyc + 16; i++) begin
      e_gnt[i] = '0; e_rv[i] = '0; e_wr[i] = 0; e_act[i] = 0; e_addr[i] = '0; e_data[i] = '0;
    end
    next_free = 0;
    last_ldr = 1'b1;
  end

  // Every-cycle comparison against the model (all zero while in reset).
  initial forever begin
    logic [4:0] g, x;
    logic [DW-1:0] erc, erl, ed;
    logic [AW-1:0] ea;
    bit ca, cd;
    @(negedge clk);
    g = {cpu_gnt, ldr_gnt, cpu_rvalid, ldr_rvalid, mem_wren};
    if (!rst_n) begin
      x = '0; erc = '0; erl = '0; ea = '0; ed = '0; ca = 1; cd = 1;
    end else begin
      x   = {e_gnt[cyc][0], e_gnt[cyc][1], e_rv[cyc][0], e_rv[cyc][1], (|e_gnt[cyc]) && e_wr[cyc]};
      erc = e_rv[cyc][0] ? e_rd[cyc] : '0;
      erl = e_rv[cyc][1] ? e_rd[cyc] : '0;
      ca  = e_act[cyc]; ea = e_addr[cyc];
      cd  = x[0]; ed = e_data[cyc];
    end
    nvec++;
    if (g !== x || cpu_rdata !== erc || ldr_rdata !== erl ||
        (ca && mem_address !== ea) || (cd && mem_data !== ed)) begin
      nmis++;
      $display("FAIL model cyc %0d: ctl got %b exp %b cpu_rdata %h/%h ldr_rdata %h/%h addr %h/%h wdata %h/%h",
               cyc, g, x, cpu_rdata, erc, ldr_rdata, erl, mem_address, ea, mem_data, ed);
    end
  end

  int order_q[$];

  function automatic logic gnt_of(int s);
    return (s == 0) ? cpu_gnt : (s == 1) ? ldr_gnt : l2_gnt;
  endfunction
  function automatic logic rv_of(int s);
    return (s == 0) ? cpu_rvalid : (s == 1) ? ldr_rvalid : l2_rvalid;
  endfunction
  function automatic logic [DW-1:0] rd_of(int s);
    return (s == 0) ? cpu_rdata : (s == 1) ? ldr_rdata : l2_rdata;
  endfunction

  // sel: 0 = CPU, 1 = LDR, 2 = LDR of the RD_LAT=2 instance.
  task automatic access(input int sel, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        output logic [DW-1:0] rd, output int sc, output int gc, output int rc);
    bit hit;
    int n;
    rd = '0; gc = -1; rc = -1; sc = cyc;
    case (sel)
      0:       begin cpu_req = 1; cpu_wren = wr; cpu_addr = a; cpu_wdata = d; end
      1:       begin ldr_req = 1; ldr_wren = wr; ldr_addr = a; ldr_wdata = d; end
      default: begin l2_req = 1; l2_wren = wr; l2_addr = a; l2_wdata = d; end
    endcase
    hit = 0; n = 0;
    while (!hit && n < 60) begin @(posedge clk); #2; n++; hit = gnt_of(sel); end
    case (sel)
      0:       cpu_req = 0;
      1:       ldr_req = 0;
      default: l2_req = 0;
    endcase
    chk("gnt_seen", 64'(hit), 64'(1));
    if (hit) begin gc = cyc; order_q.push_back(sel); end
    if (hit && !wr) begin
      hit = 0; n = 0;
      while (!hit && n < 20) begin @(posedge clk); #2; n++; hit = rv_of(sel); end
      chk("rvalid_seen", 64'(hit), 64'(1));
      if (hit) begin rc = cyc; rd = rd_of(sel); end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] rd;
    int sc, gc, rc, pg, nrv;
    // Test 3: both requesting out of reset, held continuously -> CPU, LDR, CPU, LDR.
    cpu_req = 1; cpu_wren = 1; cpu_addr = 12'h100; cpu_wdata = 32'h11;
    ldr_req = 1; ldr_wren = 1; ldr_addr = 12'h200; ldr_wdata = 32'h22;
    #1 rst_n = 0;
    repeat (2) @(posedge clk);
    #1 chk("reset_mem_wren", 64'(mem_wren), 64'(0));
    chk("reset_cpu_gnt", 64'(cpu_gnt), 64'(0));
    #1 rst_n = 1;
    fork
      begin
        logic [DW-1:0] r0; int s0, g0, v0;
        for (int i = 0; i < 2; i++) access(0, 1, 12'h100 + 12'(i), 32'h11 + 32'(i), r0, s0, g0, v0);
      end
      begin
        logic [DW-1:0] r1; int s1, g1, v1;
        for (int i = 0; i < 2; i++) access(1, 1, 12'h200 + 12'(i), 32'h22 + 32'(i), r1, s1, g1, v1);
      end
    join
    chk("t3_count", 64'(order_q.size()), 64'(4));
    if (order_q.size() == 4)
      chk("t3_order", {32'(order_q[0]), 8'(order_q[1]), 8'(order_q[2]), 8'(order_q[3])},
          {32'd0, 8'd1, 8'd0, 8'd1});
    repeat (3) @(posedge clk); #2;

    // Test 1: lone CPU write.
    access(0, 1, 12'h010, 32'hDEADBEEF, rd, sc, gc, rc);
    chk("t1_gnt_latency", 64'(gc - sc), 64'(1));
    chk("t1_mem_wren", 64'(mem_wren), 64'(1));
    chk("t1_mem_address", 64'(mem_address), 64'h010);
    chk("t1_mem_data", 64'(mem_data), 64'hDEADBEEF);
    @(posedge clk); #2;
    chk("t1_wren_one_cycle", 64'(mem_wren), 64'(0));
    repeat (2) @(posedge clk); #2;

    // Test 2: CPU reads it back.
    access(0, 0, 12'h010, '0, rd, sc, gc, rc);
    chk("t2_rdata", 64'(rd), 64'hDEADBEEF);
    chk("t2_rvalid_latency", 64'(rc - gc), 64'(1));
    chk("t2_ldr_rvalid", 64'(ldr_rvalid), 64'(0));
    repeat (2) @(posedge clk); #2;

    // Test 4: back-to-back LDR writes, then CPU reads.
    pg = -1;
    for (int i = 0; i < 4; i++) begin
      access(1, 1, 12'(i), 32'(i + 1), rd, sc, gc, rc);
      if (pg >= 0) chk("t4_wr_spacing", 64'(gc - pg), 64'(2));
      pg = gc;
    end
    pg = -1;
    for (int i = 0; i < 4; i++) begin
      access(0, 0, 12'(i), '0, rd, sc, gc, rc);
      chk("t4_rdata", 64'(rd), 64'(i + 1));
      if (pg >= 0) chk("t4_rd_spacing", 64'(gc - pg), 64'(3));
      pg = gc;
    end
    repeat (2) @(posedge clk); #2;

    // Test 5: RD_LAT=2 instance.
    access(2, 1, 12'h005, 32'h12345678, rd, sc, gc, rc);
    repeat (2) @(posedge clk); #2;
    access(2, 0, 12'h005, '0, rd, sc, gc, rc);
    chk("t5_rvalid_latency", 64'(rc - gc), 64'(2));
    chk("t5_rdata", 64'(rd), 64'h12345678);
    access(2, 0, 12'h007, '0, rd, sc, gc, rc);
    chk("t5_rdata_init", 64'(rd), 64'hA5A50007);
    chk("t5_cpu_side_idle", {c2_gnt, c2_rvalid, c2_rdata}, '0);
    repeat (2) @(posedge clk); #2;

    // Test 6: reset during WAIT of a CPU read.
    cpu_req = 1; cpu_wren = 0; cpu_addr = 12'h001;
    nrv = 0;
    while (!cpu_gnt && nrv < 60) begin @(posedge clk); #2; nrv++; end
    cpu_req = 0;
    chk("t6_gnt_seen", 64'(cpu_gnt), 64'(1));
    @(posedge clk); #2;
    rst_n = 0;
    #1;
    chk("t6_reset_outputs", {cpu_gnt, cpu_rvalid, ldr_gnt, ldr_rvalid, mem_wren, cpu_rdata},
        '0);
    chk("t6_reset_addr", 64'(mem_address), 64'(0));
    repeat (2) @(posedge clk); #2;
    rst_n = 1;
    nrv = 0;
    repeat (6) begin @(posedge clk); #2; nrv += int'(cpu_rvalid); end
    chk("t6_no_rvalid_after_reset", 64'(nrv), 64'(0));
    order_q.delete();
    fork
      begin logic [DW-1:0] r0; int s0, g0, v0; access(0, 1, 12'h300, 32'h33, r0, s0, g0, v0); end
      begin logic [DW-1:0] r1; int s1, g1, v1; access(1, 1, 12'h301, 32'h44, r1, s1, g1, v1); end
    join
    chk("t6_first_after_reset", 64'(order_q.size() > 0 ? order_q[0] : 9), 64'(0));
    repeat (4) @(posedge clk); #2;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
